// File: rtl/multi_queue_v2.sv
// multi_queue_v2: multi-port in-order queue with clamped push/pop counts.
// One logical circular buffer of CHANNEL*DEPTH entries, interleaved across CHANNEL banks.
module multi_queue_v2 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CHANNEL      = 4,
    parameter int unsigned PUSH_CHANNEL = 3,
    parameter int unsigned POP_CHANNEL  = 3,
    parameter int unsigned AFULL_THRESH = CHANNEL*DEPTH-PUSH_CHANNEL
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     stall_push,
    input  logic                                     stall_pop,
    input  logic [PUSH_CHANNEL*DATA_WIDTH-1:0]       data_push,
    input  logic [$clog2(PUSH_CHANNEL+1)-1:0]        push_num,
    output logic [$clog2(PUSH_CHANNEL+1)-1:0]        push_accept_num,
    output logic [POP_CHANNEL*DATA_WIDTH-1:0]        data_pop,
    output logic [POP_CHANNEL-1:0]                   pop_valid,
    input  logic [$clog2(POP_CHANNEL+1)-1:0]         pop_num,
    output logic [$clog2(POP_CHANNEL+1)-1:0]         pop_accept_num,
    output logic [$clog2(CHANNEL*DEPTH+1)-1:0]       count,
    output logic [$clog2(CHANNEL*DEPTH+1)-1:0]       free_cnt,
    output logic                                     full,
    output logic                                     empty,
    output logic                                     almost_full
);

    localparam int unsigned N      = CHANNEL * DEPTH;
    localparam int unsigned PTR_W  = $clog2(N);
    localparam int unsigned BANK_W = $clog2(CHANNEL);
    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned PUSH_W = $clog2(PUSH_CHANNEL + 1);
    localparam int unsigned POP_W  = $clog2(POP_CHANNEL + 1);

    logic [DATA_WIDTH-1:0] mem_q [CHANNEL][DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      free_w;
    logic [CNT_W-1:0]      push_req, pop_req;
    logic [CNT_W-1:0]      push_acc, pop_acc;
    logic [PTR_W-1:0]      wr_slot [PUSH_CHANNEL];
    logic [PTR_W-1:0]      rd_slot [POP_CHANNEL];

    // Saturate illegal requests, then clamp to what registered occupancy allows
    always_comb begin
        push_req = (CNT_W'(push_num) > CNT_W'(PUSH_CHANNEL)) ? CNT_W'(PUSH_CHANNEL) : CNT_W'(push_num);
        pop_req  = (CNT_W'(pop_num)  > CNT_W'(POP_CHANNEL))  ? CNT_W'(POP_CHANNEL)  : CNT_W'(pop_num);
        free_w   = CNT_W'(N) - count_q;
        push_acc = '0;
        pop_acc  = '0;
        if (!(stall_push || flush)) begin
            push_acc = (push_req < free_w) ? push_req : free_w;
        end
        if (!(stall_pop || flush)) begin
            pop_acc = (pop_req < count_q) ? pop_req : count_q;
        end
        push_accept_num = PUSH_W'(push_acc);
        pop_accept_num  = POP_W'(pop_acc);
    end

    // Pointer and occupancy update; flush returns everything to origin
    always_comb begin
        head_d  = head_q + PTR_W'(pop_acc);
        tail_d  = tail_q + PTR_W'(push_acc);
        count_d = count_q + push_acc - pop_acc;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Logical slot addresses for each write and read lane
    always_comb begin
        for (int j = 0; j < PUSH_CHANNEL; j++) begin
            wr_slot[j] = tail_q + PTR_W'(j);
        end
        for (int i = 0; i < POP_CHANNEL; i++) begin
            rd_slot[i] = head_q + PTR_W'(i);
        end
    end

    // Banked storage: consecutive slots map to distinct banks, so lanes never collide
    always_ff @(posedge clk) begin
        for (int j = 0; j < PUSH_CHANNEL; j++) begin
            if (CNT_W'(j) < push_acc) begin
                mem_q[wr_slot[j][BANK_W-1:0]][wr_slot[j][PTR_W-1:BANK_W]] <=
                    data_push[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Head window read straight from storage
    always_comb begin
        data_pop  = '0;
        pop_valid = '0;
        for (int i = 0; i < POP_CHANNEL; i++) begin
            data_pop[i*DATA_WIDTH +: DATA_WIDTH] =
                mem_q[rd_slot[i][BANK_W-1:0]][rd_slot[i][PTR_W-1:BANK_W]];
            pop_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    // Status flags derived from registered occupancy
    always_comb begin
        count       = count_q;
        free_cnt    = free_w;
        full        = (free_w < CNT_W'(PUSH_CHANNEL));
        empty       = (count_q == '0);
        almost_full = (count_q >= CNT_W'(AFULL_THRESH));
    end

`ifndef SYNTHESIS
    a_push_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
        CNT_W'(push_num) <= CNT_W'(PUSH_CHANNEL));
    a_pop_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
        CNT_W'(pop_num) <= CNT_W'(POP_CHANNEL));
`endif

endmodule

// File: tb/tb_multi_queue_v2.sv
// Scoreboard bench for multi_queue_v2 with default parameters.
module tb_multi_queue_v2;

    localparam int DW = 32;
    localparam int N  = 32;
    localparam int PC = 3;
    localparam int QC = 3;

    logic              clk = 1'b0;
    logic              rst_n, flush, stall_push, stall_pop;
    logic [PC*DW-1:0]  data_push;
    logic [1:0]        push_num, push_accept_num;
    logic [QC*DW-1:0]  data_pop;
    logic [QC-1:0]     pop_valid;
    logic [1:0]        pop_num, pop_accept_num;
    logic [5:0]        count, free_cnt;
    logic              full, empty, almost_full;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mcount   = 0;
    int          exp_push = 0;
    int          exp_pop  = 0;
    logic [31:0] seq      = 32'h100;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    multi_queue_v2 dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_push(stall_push), .stall_pop(stall_pop),
        .data_push(data_push), .push_num(push_num), .push_accept_num(push_accept_num),
        .data_pop(data_pop), .pop_valid(pop_valid), .pop_num(pop_num),
        .pop_accept_num(pop_accept_num), .count(count), .free_cnt(free_cnt),
        .full(full), .empty(empty), .almost_full(almost_full)
    );

    // Apply one cycle of requests and compute the model's expected accept counts
    task automatic drive(input int pn, input int qn, input logic fl, input logic sp, input logic sq);
        push_num   = 2'(pn);
        pop_num    = 2'(qn);
        flush      = fl;
        stall_push = sp;
        stall_pop  = sq;
        for (int i = 0; i < PC; i++) data_push[i*DW +: DW] = seq + 32'(i);
        exp_push = (sp || fl) ? 0 : ((pn < N - mcount) ? pn : N - mcount);
        exp_pop  = (sq || fl) ? 0 : ((qn < mcount) ? qn : mcount);
        #2;
    endtask

    // Retire the cycle in the model and advance to just after the clock edge
    task automatic commit();
        for (int i = 0; i < exp_pop; i++) void'(sb.pop_front());
        for (int i = 0; i < exp_push; i++) sb.push_back(seq + 32'(i));
        seq    = seq + 32'(exp_push);
        mcount = mcount + exp_push - exp_pop;
        if (flush) begin
            mcount = 0;
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 6'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (free_cnt !== 6'd32) $display("FAIL reset_free got %0d exp 32", free_cnt); else n_pass++;
        n_checks++; if ({empty, full, almost_full} !== 3'b100) $display("FAIL reset_flags got %b exp 100", {empty, full, almost_full}); else n_pass++;
        n_checks++; if (pop_valid !== 3'b000) $display("FAIL reset_pop_valid got %b exp 000", pop_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int c = 0; c < 12; c++) begin
            drive(3, 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (int'(push_accept_num) !== exp_push) $display("FAIL fill_accept cyc %0d got %0d exp %0d", c, push_accept_num, exp_push);
            else n_pass++;
            commit();
        end
        n_checks++; if (int'(count) !== 32) $display("FAIL fill_count got %0d exp 32", count); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else n_pass++;
        n_checks++; if (data_pop[DW-1:0] !== 32'h100) $display("FAIL fill_head got %h exp 100", data_pop[DW-1:0]); else n_pass++;
    endtask

    task automatic test_pop_push_full();
        drive(3, 3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (pop_accept_num !== 2'd3) $display("FAIL full_pop_acc got %0d exp 3", pop_accept_num); else n_pass++;
        n_checks++; if (push_accept_num !== 2'd0) $display("FAIL full_push_acc got %0d exp 0", push_accept_num); else n_pass++;
        commit();
        n_checks++; if (int'(count) !== 29) $display("FAIL full_count got %0d exp 29", count); else n_pass++;
        n_checks++; if (data_pop[DW-1:0] !== 32'h103) $display("FAIL full_head got %h exp 103", data_pop[DW-1:0]); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 20; c++) begin
            drive(3, 3, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (int'(push_accept_num) !== exp_push || int'(pop_accept_num) !== exp_pop)
                $display("FAIL wrap_acc cyc %0d got %0d/%0d exp %0d/%0d", c, push_accept_num, pop_accept_num, exp_push, exp_pop);
            else n_pass++;
            for (int i = 0; i < QC; i++) begin
                n_checks++;
                if (data_pop[i*DW +: DW] !== sb[i]) $display("FAIL wrap_data cyc %0d lane %0d got %h exp %h", c, i, data_pop[i*DW +: DW], sb[i]);
                else n_pass++;
            end
            commit();
            n_checks++; if (int'(count) !== mcount) $display("FAIL wrap_count cyc %0d got %0d exp %0d", c, count, mcount); else n_pass++;
        end
    endtask

    task automatic test_drain();
        while (mcount > 2) begin
            drive(0, 3, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (data_pop[DW-1:0] !== sb[0]) $display("FAIL drain_data got %h exp %h", data_pop[DW-1:0], sb[0]);
            else n_pass++;
            commit();
        end
        drive(0, 3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (pop_accept_num !== 2'd2) $display("FAIL drain_pop_acc got %0d exp 2", pop_accept_num); else n_pass++;
        n_checks++; if (pop_valid !== 3'b011) $display("FAIL drain_pop_valid got %b exp 011", pop_valid); else n_pass++;
        n_checks++; if (data_pop[2*DW-1:DW] !== sb[1]) $display("FAIL drain_lane1 got %h exp %h", data_pop[2*DW-1:DW], sb[1]); else n_pass++;
        commit();
        n_checks++; if (empty !== 1'b1 || count !== 6'd0) $display("FAIL drain_empty got %b/%0d exp 1/0", empty, count); else n_pass++;
    endtask

    task automatic test_stall();
        drive(3, 0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (push_accept_num !== 2'd0) $display("FAIL stall_push_acc got %0d exp 0", push_accept_num); else n_pass++;
        commit();
        drive(2, 0, 1'b0, 1'b0, 1'b0);
        commit();
        drive(0, 3, 1'b0, 1'b0, 1'b1);
        n_checks++; if (pop_accept_num !== 2'd0) $display("FAIL stall_pop_acc got %0d exp 0", pop_accept_num); else n_pass++;
        commit();
        n_checks++; if (int'(count) !== 2) $display("FAIL stall_count got %0d exp 2", count); else n_pass++;
    endtask

    task automatic test_flush();
        while (mcount < 10) begin
            drive((10 - mcount > 3) ? 3 : 10 - mcount, 0, 1'b0, 1'b0, 1'b0);
            commit();
        end
        n_checks++; if (int'(count) !== 10) $display("FAIL flush_pre_count got %0d exp 10", count); else n_pass++;
        drive(3, 3, 1'b1, 1'b0, 1'b0);
        n_checks++; if ({push_accept_num, pop_accept_num} !== 4'd0) $display("FAIL flush_acc got %0d/%0d exp 0/0", push_accept_num, pop_accept_num); else n_pass++;
        commit();
        n_checks++; if (count !== 6'd0 || empty !== 1'b1) $display("FAIL flush_count got %0d/%b exp 0/1", count, empty); else n_pass++;
        drive(2, 0, 1'b0, 1'b0, 1'b0);
        commit();
        n_checks++;
        if (data_pop[2*DW-1:0] !== {sb[1], sb[0]}) $display("FAIL flush_after got %h exp %h", data_pop[2*DW-1:0], {sb[1], sb[0]});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        while (mcount < 17) begin
            drive((17 - mcount > 3) ? 3 : 17 - mcount, 0, 1'b0, 1'b0, 1'b0);
            commit();
        end
        n_checks++; if (int'(count) !== 17) $display("FAIL arst_pre_count got %0d exp 17", count); else n_pass++;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 6'd0 || pop_valid !== 3'b000) $display("FAIL arst_clear got %0d/%b exp 0/000", count, pop_valid); else n_pass++;
        n_checks++; if (free_cnt !== 6'd32 || empty !== 1'b1) $display("FAIL arst_flags got %0d/%b exp 32/1", free_cnt, empty); else n_pass++;
        mcount = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (push_accept_num !== 2'd1 || pop_valid !== 3'b000) $display("FAIL arst_push got %0d/%b exp 1/000", push_accept_num, pop_valid); else n_pass++;
        commit();
        n_checks++; if (pop_valid !== 3'b001) $display("FAIL arst_valid got %b exp 001", pop_valid); else n_pass++;
        n_checks++; if (data_pop[DW-1:0] !== sb[0]) $display("FAIL arst_data got %h exp %h", data_pop[DW-1:0], sb[0]); else n_pass++;
        while (mcount < 31) begin
            drive((mcount >= 27) ? 1 : 3, 0, 1'b0, 1'b0, 1'b0);
            commit();
            n_checks++;
            if (almost_full !== (mcount >= 29)) $display("FAIL afull cnt %0d got %b exp %b", mcount, almost_full, (mcount >= 29));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_push_full();
        test_wrap();
        test_drain();
        test_stall();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
